mux_scan_sequencer: RTL and testbench

Drives the select lines of the 4-to-1 mux (`S0`/`S1`) and captures its output `Y` for each of the four data channels in turn. One scan frame steps channel 0→3, holds each select for `DWELL` cycles, and samples `Y` on the last cycle of each hold. At the end of the frame it presents a 4-bit snapshot with a one-cycle valid strobe. It sits directly upstream of the mux on the select side and consumes the mux output; it is the mux's only select source.

---
 rtl/mux_scan_pkg.sv | 18 +
 rtl/mux_dwell_counter.sv | 37 +++
 rtl/mux_scan_sequencer.sv | 118 +++++++++++
 tb/tb_mux_scan_sequencer.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mux_scan_pkg.sv
// Shared types and constants for the 4-channel mux scan sequencer.
// Holds the FSM state encoding, the channel count and the select width.
package mux_scan_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SCAN = 1'b1
   } scan_state_t;

   localparam int NUM_CH = 4;
   localparam int SEL_W  = 2;

   // Channel advance; the last channel wraps back to channel 0.
   function automatic logic [SEL_W-1:0] next_ch(input logic [SEL_W-1:0] c);
      return c + 2'd1;
   endfunction

endpackage

// File: rtl/mux_dwell_counter.sv
// Dwell timer for one select hold.
// Counts 0..DWELL-1 while enabled and flags the last cycle of each hold.
module mux_dwell_counter #(
   parameter int DWELL = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
);

   localparam int            CW   = (DWELL > 1) ? $clog2(DWELL) : 1;
   localparam logic [CW-1:0] LAST = CW'(DWELL - 1);

   logic [CW-1:0] dcnt_r;

   // Dwell count register: cleared outside a scan, wraps after the last hold cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dcnt_r <= '0;
      end else if (clr) begin
         dcnt_r <= '0;
      end else if (en) begin
         if (dcnt_r == LAST) begin
            dcnt_r <= '0;
         end else begin
            dcnt_r <= dcnt_r + CW'(1);
         end
      end else begin
         dcnt_r <= dcnt_r;
      end
   end

   assign tc = en && (dcnt_r == LAST);

endmodule

// File: rtl/mux_scan_sequencer.sv
// Steps the 4-to-1 mux selects through channels 0..3, samples Y on the last
// dwell cycle of each channel and publishes a 4-bit snapshot per frame.
module mux_scan_sequencer
   import mux_scan_pkg::*;
#(
   parameter int DWELL = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       continuous,
   input  logic       abort,
   input  logic       Y,
   output logic       S0,
   output logic       S1,
   output logic       busy,
   output logic [3:0] sample,
   output logic       sample_valid
);

   localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

   scan_state_t        state_r, state_nx;
   logic [SEL_W-1:0]   ch_r, ch_nx;
   logic [NUM_CH-1:0]  shadow_r, shadow_nx;
   logic [NUM_CH-1:0]  sample_r, sample_nx;
   logic               valid_r, valid_nx;
   logic               tc_s;
   logic               dcnt_clr_s;
   logic               dcnt_en_s;

   // The counter is held at zero whenever we are not scanning so every frame starts aligned.
   assign dcnt_en_s  = (state_r == SCAN);
   assign dcnt_clr_s = abort || (state_r != SCAN);

   mux_dwell_counter #(
      .DWELL (DWELL)
   ) u_dwell (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (dcnt_clr_s),
      .en    (dcnt_en_s),
      .tc    (tc_s)
   );

   // State, channel, shadow and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r  <= IDLE;
         ch_r     <= '0;
         shadow_r <= '0;
         sample_r <= '0;
         valid_r  <= 1'b0;
      end else begin
         state_r  <= state_nx;
         ch_r     <= ch_nx;
         shadow_r <= shadow_nx;
         sample_r <= sample_nx;
         valid_r  <= valid_nx;
      end
   end

   // Next-state, channel stepping and capture logic; abort overrides everything.
   always_comb begin
      state_nx  = state_r;
      ch_nx     = ch_r;
      shadow_nx = shadow_r;
      sample_nx = sample_r;
      valid_nx  = 1'b0;
      if (abort) begin
         state_nx  = IDLE;
         ch_nx     = '0;
         shadow_nx = '0;
      end else begin
         case (state_r)
            IDLE: begin
               ch_nx = '0;
               if (start) begin
                  state_nx = SCAN;
               end else begin
                  state_nx = IDLE;
               end
            end
            SCAN: begin
               if (tc_s) begin
                  shadow_nx[ch_r] = Y;
                  ch_nx           = next_ch(ch_r);
                  if (ch_r == LAST_CH) begin
                     sample_nx = {Y, shadow_r[2:0]};
                     valid_nx  = 1'b1;
                     if (continuous) begin
                        state_nx = SCAN;
                     end else begin
                        state_nx = IDLE;
                     end
                  end else begin
                     state_nx = SCAN;
                  end
               end else begin
                  state_nx = SCAN;
               end
            end
            default: begin
               state_nx  = IDLE;
               ch_nx     = '0;
               shadow_nx = '0;
            end
         endcase
      end
   end

   assign S0           = ch_r[0];
   assign S1           = ch_r[1];
   assign busy         = (state_r == SCAN);
   assign sample       = sample_r;
   assign sample_valid = valid_r;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Directed bench for mux_scan_sequencer with a behavioural 4-to-1 mux model
// and a queue of expected frame snapshots compared on every strobe.
module tb_mux_scan_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic       continuous = 1'b0;
   logic       abort = 1'b0;
   logic       Y;
   logic       S0, S1, busy, sample_valid;
   logic [3:0] sample;

   logic [3:0] d = 4'b0000;
   logic       glitch = 1'b0;
   logic       y_g = 1'b0;
   logic [3:0] exp_q[$];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   assign Y = glitch ? y_g : d[{S1, S0}];

   mux_scan_sequencer #(.DWELL(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .continuous   (continuous),
      .abort        (abort),
      .Y            (Y),
      .S0           (S0),
      .S1           (S1),
      .busy         (busy),
      .sample       (sample),
      .sample_valid (sample_valid)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Walks n cycles after the start edge, checking selects/busy/strobe timing.
   task automatic run_check(input int n, input logic [3:0] nd);
      for (int i = 0; i < n; i++) begin
         y_g = (i % 4 == 3) ? d[(i % 16) / 4] : ~d[(i % 16) / 4];
         check("sel", {30'd0, S1, S0}, (i % 16) / 4);
         check("busy_scan", busy, 1'b1);
         check("valid_timing", sample_valid, (i > 0) && (i % 16 == 0));
         if (i == 16) begin
            d = nd;
            continuous = 1'b0;
         end
         step(1);
      end
   endtask

   // Scoreboard: every strobe must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && sample_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_strobe", 1'b1, 1'b0);
         end else begin
            check("sb_sample", sample, exp_q.pop_front());
         end
      end
   end

   initial begin
      #2 rst_n = 1'b0;
      #1;
      check("rst_sel", {30'd0, S1, S0}, 32'd0);
      check("rst_busy", busy, 1'b0);
      check("rst_sample", sample, 4'b0000);
      check("rst_valid", sample_valid, 1'b0);
      step(2);
      rst_n = 1'b1;
      step(1);

      // Single frame, D0..D3 = 1,0,1,1
      d = 4'b1101;
      exp_q.push_back(4'b1101);
      start = 1'b1;
      step(1);
      start = 1'b0;
      run_check(16, d);
      check("t1_valid", sample_valid, 1'b1);
      check("t1_sample", sample, 4'b1101);
      check("t1_busy_fall", busy, 1'b0);
      step(1);
      check("t1_valid_one_cycle", sample_valid, 1'b0);
      step(2);

      // Continuous: two back-to-back frames, data changed to 0,1,1,0 in between
      continuous = 1'b1;
      exp_q.push_back(4'b1101);
      exp_q.push_back(4'b0110);
      start = 1'b1;
      step(1);
      start = 1'b0;
      run_check(32, 4'b0110);
      check("t2_valid", sample_valid, 1'b1);
      check("t2_sample", sample, 4'b0110);
      check("t2_busy_fall", busy, 1'b0);
      step(2);

      // Abort during channel 2
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(9);
      check("t3_pre_sel", {30'd0, S1, S0}, 32'd2);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      check("t3_busy", busy, 1'b0);
      check("t3_sel", {30'd0, S1, S0}, 32'd0);
      for (int i = 0; i < 20; i++) begin
         check("t3_no_strobe", sample_valid, 1'b0);
         check("t3_sample_kept", sample, 4'b0110);
         step(1);
      end

      // Asynchronous reset in channel 1
      d = 4'b1101;
      start = 1'b1;
      step(1);
      start = 1'b0;
      step(5);
      check("t4_pre_sel", {30'd0, S1, S0}, 32'd1);
      rst_n = 1'b0;
      #2;
      check("t4_sel", {30'd0, S1, S0}, 32'd0);
      check("t4_busy", busy, 1'b0);
      check("t4_sample", sample, 4'b0000);
      check("t4_valid", sample_valid, 1'b0);
      step(2);
      rst_n = 1'b1;
      step(1);
      exp_q.push_back(4'b1101);
      start = 1'b1;
      step(1);
      start = 1'b0;
      run_check(16, d);
      check("t4_clean_sample", sample, 4'b1101);
      check("t4_clean_valid", sample_valid, 1'b1);
      step(2);

      // Y glitches except on the last dwell cycle of each channel
      d = 4'b1010;
      glitch = 1'b1;
      exp_q.push_back(4'b1010);
      start = 1'b1;
      step(1);
      start = 1'b0;
      run_check(16, d);
      check("t5_sample", sample, 4'b1010);
      glitch = 1'b0;
      step(2);

      // start held high: re-trigger after one idle cycle
      d = 4'b0011;
      exp_q.push_back(4'b0011);
      exp_q.push_back(4'b0011);
      start = 1'b1;
      step(1);
      run_check(16, d);
      check("t6_valid1", sample_valid, 1'b1);
      check("t6_idle_gap", busy, 1'b0);
      check("t6_sample1", sample, 4'b0011);
      step(1);
      start = 1'b0;
      run_check(16, d);
      check("t6_valid2", sample_valid, 1'b1);
      check("t6_busy_fall", busy, 1'b0);
      step(2);

      // start and abort together: abort wins
      start = 1'b1;
      abort = 1'b1;
      step(1);
      check("t6_abort_wins", busy, 1'b0);
      step(1);
      check("t6_abort_hold", busy, 1'b0);
      start = 1'b0;
      abort = 1'b0;
      step(3);
      check("t6_still_idle", busy, 1'b0);
      check("t6_sample_kept", sample, 4'b0011);

      check("sb_drained", exp_q.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
